// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter:
// register indices, STATUS bit positions, serialiser states.
package uart_tx_mmio_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // A divisor of 0 would stall the bit timer, so it runs as 1.
    function automatic logic [15:0] eff_div_of(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous circular-buffer FIFO.
// Ports: clk, reset (sync, high), push/din, pop/dout, full, empty, count.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIVISOR registers.
// Ports: clk, reset, sel/addr/re/we/wdata/rdata bus, tx serial out.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [29:0] addr,
    input  logic        re,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    idx;
    logic          wr_data;
    logic          rd_status;
    logic [15:0]   divisor;
    logic          ovf;
    logic          ovf_set;
    logic [31:0]   status;
    logic [31:0]   cnt_w;
    logic [3:0]    cnt_sat;

    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    dout;
    logic          pop;

    logic [1:0]    state;
    logic [7:0]    shift;
    logic [15:0]   eff_div;
    logic [15:0]   cnt;
    logic [2:0]    bit_idx;
    logic          bit_end;

    logic          unused;
    assign unused = ^{addr[29:2], we[3:2], wdata[31:16]};

    assign idx       = addr[1:0];
    assign wr_data   = sel && we[0] && (idx == REG_DATA);
    assign rd_status = sel && re && (idx == REG_STATUS);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign ovf_set = wr_data && full && !pop;

    assign cnt_w   = 32'(count);
    assign cnt_sat = (cnt_w > 32'd15) ? 4'hF : cnt_w[3:0];

    always_comb begin
        status                     = '0;
        status[ST_BUSY]            = (state != S_IDLE);
        status[ST_FULL]            = full;
        status[ST_EMPTY]           = empty;
        status[ST_OVF]             = ovf;
        status[ST_CNT_LSB +: 4]    = cnt_sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata   <= '0;
            ovf     <= 1'b0;
            divisor <= DIV_RESET;
        end else begin
            if (sel && re) begin
                unique case (idx)
                    REG_STATUS: rdata <= status;
                    REG_DIV:    rdata <= {16'b0, divisor};
                    default:    rdata <= '0;
                endcase
            end
            // A fresh overflow outranks the clear-on-read.
            if (ovf_set)        ovf <= 1'b1;
            else if (rd_status) ovf <= 1'b0;
            if (sel && idx == REG_DIV) begin
                if (we[0]) divisor[7:0]  <= wdata[7:0];
                if (we[1]) divisor[15:8] <= wdata[15:8];
            end
        end
    end

    assign bit_end = (cnt == eff_div - 16'd1);

    always_comb begin
        pop = 1'b0;
        if (state == S_IDLE)
            pop = !empty;
        else if (state == S_STOP && bit_end)
            pop = !empty;
    end

    // tx is registered alongside the state so it changes on the same
    // edge as each transition, glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            eff_div <= 16'd1;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= dout;
                        eff_div <= eff_div_of(divisor);
                        cnt     <= '0;
                        state   <= S_START;
                        tx      <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= shift[0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (pop) begin
                            shift   <= dout;
                            eff_div <= eff_div_of(divisor);
                            state   <= S_START;
                            tx      <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: frame-level model plus
// directed register/serial scenarios.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic [29:0] addr = '0;
    logic        re = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;

    int checks = 0;
    int failures = 0;
    bit checking = 0;

    uart_tx_mmio dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .re    (re),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    // Model: queue of pending bytes, current frame byte, position k
    // within a 10*d-cycle frame.
    logic [7:0]  m_q[$];
    bit          m_in = 0;
    int          m_k = 0;
    int          m_d = 1;
    logic [7:0]  m_cur = '0;
    bit          m_ovf = 0;
    logic [15:0] m_div = 16'd104;
    logic [31:0] m_rdata = '0;

    always @(posedge clk) begin
        int sz;
        bit pop;
        bit set;
        logic [31:0] stat;
        logic [3:0] c;
        if (reset) begin
            m_q.delete();
            m_in = 0;
            m_k = 0;
            m_ovf = 0;
            m_div = 16'd104;
            m_rdata = '0;
        end else begin
            sz = m_q.size();
            c = (sz > 15) ? 4'hF : 4'(sz);
            stat = {24'b0, c, m_ovf, (sz == 0), (sz == 8), m_in};
            if (sel && re) begin
                if (addr[1:0] == 2'd1)      m_rdata = stat;
                else if (addr[1:0] == 2'd2) m_rdata = {16'b0, m_div};
                else                        m_rdata = '0;
            end
            pop = (sz > 0) && (!m_in || m_k == 10 * m_d - 1);
            if (m_in) begin
                m_k++;
                if (m_k == 10 * m_d) m_in = 0;
            end
            if (pop) begin
                m_cur = m_q.pop_front();
                m_d = (m_div == 0) ? 1 : int'(m_div);
                m_in = 1;
                m_k = 0;
            end
            set = 0;
            if (sel && we[0] && addr[1:0] == 2'd0) begin
                if (sz < 8 || pop) m_q.push_back(wdata[7:0]);
                else set = 1;
            end
            if (set) m_ovf = 1;
            else if (sel && re && addr[1:0] == 2'd1) m_ovf = 0;
            if (sel && addr[1:0] == 2'd2) begin
                if (we[0]) m_div[7:0] = wdata[7:0];
                if (we[1]) m_div[15:8] = wdata[15:8];
            end
        end
    end

    function automatic logic exp_tx();
        logic [7:0] b;
        if (!m_in) return 1'b1;
        if (m_k < m_d) return 1'b0;
        if (m_k < 9 * m_d) begin
            b = m_cur;
            return b[(m_k - m_d) / m_d];
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("tx_model", {31'b0, tx}, {31'b0, exp_tx()});
            chk("rdata_model", rdata, m_rdata);
        end
    end

    task automatic wr(input logic [1:0] a, input logic [3:0] w,
                      input logic [31:0] d);
        sel = 1'b1;
        addr = {28'b0, a};
        we = w;
        wdata = d;
        @(negedge clk);
        sel = 1'b0;
        we = '0;
        wdata = '0;
        addr = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1;
        re = 1'b1;
        addr = {28'b0, a};
        @(negedge clk);
        d = rdata;
        sel = 1'b0;
        re = 1'b0;
        addr = '0;
    endtask

    logic [31:0] v;
    int busy_cnt;

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checking = 1;

        // 1: reset state
        chk("reset_tx", {31'b0, tx}, 32'd1);
        chk("reset_rdata", rdata, 32'h0);
        rd(2'd1, v);
        chk("reset_status", v, 32'h4);
        rd(2'd2, v);
        chk("reset_div", v, 32'h68);

        // 2: single 0x55 frame at divisor 4
        wr(2'd2, 4'b0011, 32'd4);
        wr(2'd0, 4'b0001, 32'h55);
        busy_cnt = 0;
        sel = 1'b1;
        re = 1'b1;
        addr = 30'd1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rdata[0]) busy_cnt++;
            if (i == 2)  chk("t2_start", {31'b0, tx}, 32'd0);
            if (i == 6)  chk("t2_bit0", {31'b0, tx}, 32'd1);
            if (i == 10) chk("t2_bit1", {31'b0, tx}, 32'd0);
            if (i == 38) chk("t2_stop", {31'b0, tx}, 32'd1);
        end
        sel = 1'b0;
        re = 1'b0;
        addr = '0;
        chk("t2_busy_cycles", busy_cnt, 32'd40);

        // 3: three back-to-back frames at divisor 2
        wr(2'd2, 4'b0011, 32'd2);
        wr(2'd0, 4'b0001, 32'h01);
        wr(2'd0, 4'b0001, 32'h02);
        wr(2'd0, 4'b0001, 32'h03);
        rd(2'd1, v);
        chk("t3_status_cnt2", v, 32'h21);
        repeat (70) @(negedge clk);
        rd(2'd1, v);
        chk("t3_idle", v, 32'h4);

        // 5: divisor 0 runs as 1; byte-lane divisor write
        wr(2'd2, 4'b0011, 32'd0);
        wr(2'd0, 4'b0001, 32'hA5);
        busy_cnt = 0;
        sel = 1'b1;
        re = 1'b1;
        addr = 30'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdata[0]) busy_cnt++;
        end
        sel = 1'b0;
        re = 1'b0;
        addr = '0;
        chk("t5_busy_cycles", busy_cnt, 32'd10);
        wr(2'd2, 4'b0010, 32'h00001200);
        rd(2'd2, v);
        chk("t5_div_lane", v, 32'h1200);
        wr(2'd3, 4'b1111, 32'hFFFFFFFF);
        rd(2'd3, v);
        chk("t5_reserved", v, 32'h0);

        // 4: overflow at divisor 1000
        wr(2'd2, 4'b0011, 32'd1000);
        for (int i = 0; i < 10; i++) wr(2'd0, 4'b0001, 32'h10 + i);
        rd(2'd1, v);
        chk("t4_status_ovf", v, 32'h8B);
        rd(2'd1, v);
        chk("t4_status_clr", v, 32'h83);
        rd(2'd0, v);
        chk("t4_data_read", v, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // 6: reset mid data bit
        wr(2'd2, 4'b0011, 32'd8);
        wr(2'd0, 4'b0001, 32'h00);
        wr(2'd0, 4'b0001, 32'h11);
        wr(2'd0, 4'b0001, 32'h22);
        repeat (11) @(negedge clk);
        chk("t6_mid_bit", {31'b0, tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_tx_high", {31'b0, tx}, 32'd1);
        reset = 1'b0;
        rd(2'd1, v);
        chk("t6_status", v, 32'h4);
        rd(2'd2, v);
        chk("t6_div", v, 32'h68);
        repeat (100) @(negedge clk);

        checking = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
